// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - EX-stage operand forwarding select and load-use stall control
module fwd_sel_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // Shadow of the instruction in EX
    logic              ex_v_q,  ex_v_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_rw_q, ex_rw_d;
    logic              ex_mr_q, ex_mr_d;
    // Shadow of the instruction in MEM
    logic              mem_v_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_rw_q;

    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              ex_load_pending;
    logic [1:0]        dec_a;
    logic [1:0]        dec_b;

    // Forwarding choice for one source; the nearer (EX) producer wins
    function automatic logic [1:0] fwd_decide(
        input logic [REG_AW-1:0] rs,
        input logic              ev,
        input logic [REG_AW-1:0] erd,
        input logic              erw,
        input logic              emr,
        input logic              mv,
        input logic [REG_AW-1:0] mrd,
        input logic              mrw
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs == '0) begin
            sel = SEL_RF;
        end else if (ev && erw && (erd == rs) && !emr) begin
            sel = SEL_MEM;
        end else if (mv && mrw && (mrd == rs)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Load-use hazard detection; a flush squashes the consumer so it never stalls
    always_comb begin
        ex_load_pending = ex_v_q && ex_mr_q && ex_rw_q && (ex_rd_q != '0);
        stall = id_valid && ex_load_pending &&
                ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2)) && !flush;
        dec_a = fwd_decide(id_rs1, ex_v_q, ex_rd_q, ex_rw_q, ex_mr_q,
                           mem_v_q, mem_rd_q, mem_rw_q);
        dec_b = fwd_decide(id_rs2, ex_v_q, ex_rd_q, ex_rw_q, ex_mr_q,
                           mem_v_q, mem_rd_q, mem_rw_q);
    end

    // Next EX shadow entry, selects and stall counter
    always_comb begin
        ex_v_d  = 1'b0;
        ex_rd_d = id_rd;
        ex_rw_d = id_regwrite;
        ex_mr_d = id_memread;
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        cnt_d   = cnt_q;
        if (!flush && !stall && id_valid) begin
            ex_v_d  = 1'b1;
            fwd_a_d = dec_a;
            fwd_b_d = dec_b;
        end
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State advances only when the global pipeline moves
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            fwd_a_q  <= SEL_RF;
            fwd_b_q  <= SEL_RF;
            cnt_q    <= '0;
        end else if (pipe_en) begin
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_rw_q <= ex_rw_q;
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fwd_a_sel   = fwd_a_q;
    assign fwd_b_sel   = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb/tb_fwd_sel_ctrl.sv - directed self-checking bench for fwd_sel_ctrl
module tb_fwd_sel_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_en;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic [15:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    fwd_sel_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_en     (pipe_en),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; pipe_en = 1'b1; flush = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL reset_a got=%b exp=00", fwd_a_sel); end
        compared++; if (fwd_b_sel !== 2'b00) begin mismatched++; $display("FAIL reset_b got=%b exp=00", fwd_b_sel); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got=%b exp=0", stall); end
        compared++; if (stall_count !== 16'd0) begin mismatched++; $display("FAIL reset_cnt got=%0d exp=0", stall_count); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
        step();
        compared++; if (fwd_a_sel !== 2'b10) begin mismatched++; $display("FAIL b2b_a got=%b exp=10", fwd_a_sel); end
        compared++; if (fwd_b_sel !== 2'b00) begin mismatched++; $display("FAIL b2b_b got=%b exp=00", fwd_b_sel); end
        drain();
    endtask

    task automatic test_distance2();
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd7, 5'd12, 1'b1, 1'b0);
        step();
        compared++; if (fwd_b_sel !== 2'b01) begin mismatched++; $display("FAIL dist2_b got=%b exp=01", fwd_b_sel); end
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL dist2_a got=%b exp=00", fwd_a_sel); end
        drain();
    endtask

    task automatic test_double_producer();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd3, 5'd14, 1'b1, 1'b0);
        step();
        compared++; if (fwd_a_sel !== 2'b10) begin mismatched++; $display("FAIL dbl_a got=%b exp=10", fwd_a_sel); end
        compared++; if (fwd_b_sel !== 2'b10) begin mismatched++; $display("FAIL dbl_b got=%b exp=10", fwd_b_sel); end
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b0);
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL lu_stall got=%b exp=1", stall); end
        step();
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL lu_stall_once got=%b exp=0", stall); end
        compared++; if (stall_count !== 16'd1) begin mismatched++; $display("FAIL lu_cnt got=%0d exp=1", stall_count); end
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL lu_bubble_a got=%b exp=00", fwd_a_sel); end
        step();
        compared++; if (fwd_a_sel !== 2'b01) begin mismatched++; $display("FAIL lu_fwd_a got=%b exp=01", fwd_a_sel); end
        compared++; if (stall_count !== 16'd1) begin mismatched++; $display("FAIL lu_cnt_after got=%0d exp=1", stall_count); end
        drain();
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL x0_stall got=%b exp=0", stall); end
        step();
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL x0_a got=%b exp=00", fwd_a_sel); end
        compared++; if (fwd_b_sel !== 2'b00) begin mismatched++; $display("FAIL x0_b got=%b exp=00", fwd_b_sel); end
        drain();
        drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd0, 5'd2, 5'd13, 1'b1, 1'b0);
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL x0_load_stall got=%b exp=0", stall); end
        step();
        compared++; if (stall_count !== 16'd1) begin mismatched++; $display("FAIL x0_cnt got=%0d exp=1", stall_count); end
        drain();
    endtask

    task automatic test_invalid_id();
        drive(1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        step();
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL inv_a got=%b exp=00", fwd_a_sel); end
        compared++; if (fwd_b_sel !== 2'b00) begin mismatched++; $display("FAIL inv_b got=%b exp=00", fwd_b_sel); end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd10, 5'd0, 5'd4, 1'b1, 1'b1);
        step();
        compared++; if (fwd_a_sel !== 2'b10) begin mismatched++; $display("FAIL fl_pre_a got=%b exp=10", fwd_a_sel); end
        drive(1'b1, 5'd4, 5'd10, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL fl_stall got=%b exp=0", stall); end
        step();
        flush = 1'b0;
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL fl_a got=%b exp=00", fwd_a_sel); end
        compared++; if (fwd_b_sel !== 2'b00) begin mismatched++; $display("FAIL fl_b got=%b exp=00", fwd_b_sel); end
        compared++; if (stall_count !== 16'd1) begin mismatched++; $display("FAIL fl_cnt got=%0d exp=1", stall_count); end
        drain();
    endtask

    task automatic test_pipe_hold();
        drive(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd11, 5'd0, 5'd4, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd4, 5'd2, 5'd12, 1'b1, 1'b0);
        pipe_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (fwd_a_sel !== 2'b10) begin mismatched++; $display("FAIL hold_a[%0d] got=%b exp=10", i, fwd_a_sel); end
            compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, stall); end
            compared++; if (stall_count !== 16'd1) begin mismatched++; $display("FAIL hold_cnt[%0d] got=%0d exp=1", i, stall_count); end
        end
        pipe_en = 1'b1;
        step();
        compared++; if (stall_count !== 16'd2) begin mismatched++; $display("FAIL hold_cnt_resume got=%0d exp=2", stall_count); end
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL hold_bubble_a got=%b exp=00", fwd_a_sel); end
        step();
        compared++; if (fwd_a_sel !== 2'b01) begin mismatched++; $display("FAIL hold_fwd_a got=%b exp=01", fwd_a_sel); end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd1, 5'd2, 5'd15, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd15, 5'd0, 5'd4, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd4, 5'd15, 5'd6, 1'b1, 1'b0);
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL rst_pre_stall got=%b exp=1", stall); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rst_stall got=%b exp=0", stall); end
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL rst_a got=%b exp=00", fwd_a_sel); end
        compared++; if (stall_count !== 16'd0) begin mismatched++; $display("FAIL rst_cnt got=%0d exp=0", stall_count); end
        step();
        compared++; if (fwd_a_sel !== 2'b00) begin mismatched++; $display("FAIL rst_next_a got=%b exp=00", fwd_a_sel); end
        compared++; if (fwd_b_sel !== 2'b00) begin mismatched++; $display("FAIL rst_next_b got=%b exp=00", fwd_b_sel); end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance2();
        test_double_producer();
        test_load_use();
        test_x0();
        test_invalid_id();
        test_flush();
        test_pipe_hold();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
